bsc_ompss_stream_to_hs_adapter: RTL and testbench
=================================================

Name: bsc_ompss_stream_to_hs_adapter

Overview:
- Receive-side counterpart of the accelerator's hs-to-stream output adapter.
- Accepts an AXI-Stream carrying 64-bit words, a 3-bit tdest and a tlast flag from the interconnect.
- Buffers words in a small FIFO and presents them to an HLS accelerator input port using the ap_vld/ap_ack handshake.
- Packs each word into the same 68-bit layout the output adapter unpacks, so one format is used in both directions.

Parameters:
- FIFO_DEPTH, 4, number of buffered words; power of two, ≥2.
- TID_WIDTH, 4, width of inStream_tid.
- ACCID, 0, this accelerator's ID; used only under the optional feature.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- inStream_tdata  in  64  payload word.
- inStream_tdest  in  3  destination/tag field.
- inStream_tid  in  TID_WIDTH  source accelerator ID.
- inStream_tlast  in  1  last word of packet.
- inStream_tvalid  in  1  input word valid.
- inStream_tready  out  1  input word accepted.
- out_hs  out  68  packed head word: [67:4]=tdata, [3:1]=tdest, [0]=tlast.
- out_hs_ap_vld  out  1  head word valid.
- out_hs_ap_ack  in  1  HLS consumer took the head word.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- pkt_open  out  1  a packet has started on the input and its tlast has not yet been accepted.

Behaviour:
- Reset (areset=1 at an edge): FIFO emptied; pointers, level and FSM cleared.
  - Outputs after reset: inStream_tready=0 during the reset cycle, then 1; out_hs_ap_vld=0; level=0; pkt_open=0; out_hs holds don't-care (bench must not check it).
- Reset mid-packet discards all buffered words and any partial packet. The word on the bus during reset is not accepted.
- inStream_tready = !full && !areset. It is a register-derived signal with no combinational path from out_hs_ap_ack.
- Push: tvalid && tready at an edge writes {tdata, tdest, tlast} at the write pointer.
- Pop: out_hs_ap_vld && out_hs_ap_ack at an edge advances the read pointer.
- out_hs_ap_vld = (level != 0). out_hs is driven from the head entry. An ack while vld=0 is ignored.
- Latency: a word accepted at edge N gives out_hs_ap_vld=1 after edge N. There is no input-to-output bypass.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Full: tready=0, so no push occurs even if a pop happens in the same cycle. tready returns 1 the cycle after that pop.
- Empty plus push: vld rises the next cycle.
- Pointers: log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH. level ranges 0..FIFO_DEPTH.
- Ordering is strictly FIFO. tdest and tlast travel with their word unchanged.
- Packet FSM, advanced only on accepted input beats:
  - IDLE: an accepted beat with tlast=0 → MID_PKT. An accepted beat with tlast=1 is a single-word packet and stays in IDLE.
  - MID_PKT: an accepted beat with tlast=1 → IDLE.
  - DROP: exists only with the optional feature.
  - pkt_open=1 while the FSM is in MID_PKT or DROP.

Optional Feature:
- Macro: BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN.
- Defined:
  - A first beat (FSM in IDLE) with tid != ACCID is accepted (tready follows the normal full rule) but not written to the FIFO.
  - If that beat has tlast=0, the FSM enters DROP. In DROP, all beats are accepted and discarded regardless of tid. Accepting tlast=1 returns the FSM to IDLE.
  - Adds port drop_err (out, 1): sticky, set on the first discarded beat, cleared only by reset.
  - tid is sampled only on first beats; a mismatch mid-packet does not cause a drop.
- Undefined: tid is ignored, there is no DROP state, and the drop_err port does not exist.

Test Plan:
- Single word, ack held high: push tdata=0xDEADBEEF_00000001, tdest=5, tlast=1 → out_hs=0xDEADBEEF00000001_B, vld=1 exactly one cycle later; level goes 1→0; pkt_open stays 0.
- Fill, FIFO_DEPTH=4, ack=0: push 6 words (0..5) back to back → tready=0 after the 4th push; level=4; words 4 and 5 held on the bus. Then ack=1 → out_hs sequence 0,1,2,3,4,5 in order, tready returning 1 the cycle after the first pop.
- Simultaneous push/pop: level=2, continuous valid input, ack=1 → level stays 2 every cycle; no word is lost or duplicated across 20 words, including pointer wrap-around.
- Reset mid-packet: push 3 words with tlast=0, assert areset for 1 cycle while tvalid=1 → vld=0, level=0, pkt_open=0 after reset; the next packet is delivered intact.
- Packet tracking: a 3-word packet (tlast on word 3) → pkt_open is 1 after beats 1 and 2, and 0 after beat 3.
- Macro on, ACCID=2: a packet with tid=3 (2 words) followed by a packet with tid=2 (1 word) → only the tid=2 word appears on out_hs; drop_err=1 and stays 1.

Source files
------------

// File: rtl/bsc_ompss_stream_to_hs_adapter.sv
// AXI-Stream to HLS ap_vld/ap_ack input adapter with a small word FIFO and packet tracking.
// Optional tid filter enabled by defining BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN.
module bsc_ompss_stream_to_hs_adapter #(
  parameter int FIFO_DEPTH = 4,
  parameter int TID_WIDTH  = 4,
  parameter int ACCID      = 0
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [63:0]                   inStream_tdata,
  input  logic [2:0]                    inStream_tdest,
  input  logic [TID_WIDTH-1:0]          inStream_tid,
  input  logic                          inStream_tlast,
  input  logic                          inStream_tvalid,
  output logic                          inStream_tready,
  output logic [67:0]                   out_hs,
  output logic                          out_hs_ap_vld,
  input  logic                          out_hs_ap_ack,
  output logic [$clog2(FIFO_DEPTH):0]   level,
`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
  output logic                          pkt_open,
  output logic                          drop_err
`else
  output logic                          pkt_open
`endif
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;
  localparam int HS_W = 68;

`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
  typedef enum logic [1:0] {ST_IDLE, ST_MID_PKT, ST_DROP} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_MID_PKT} state_t;
`endif

  logic [HS_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  state_t          state_q, state_d;
  logic            pkt_open_q, pkt_open_d;
  logic            full, push_acc, pop_acc, wr_en, drop_beat;

  // tready depends only on the level register and reset, never on ack
  assign full            = (level_q == LW'(FIFO_DEPTH));
  assign inStream_tready = !full && !areset;
  assign push_acc        = inStream_tvalid && inStream_tready;
  assign pop_acc         = (level_q != '0) && out_hs_ap_ack;

`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
  logic drop_err_q, drop_err_d;

  assign drop_beat = push_acc &&
                     ((state_q == ST_DROP) ||
                      ((state_q == ST_IDLE) && (inStream_tid != TID_WIDTH'(ACCID))));
  assign drop_err  = drop_err_q;
`else
  logic unused_tid;

  assign unused_tid = ^{inStream_tid, TID_WIDTH'(ACCID)};
  assign drop_beat  = 1'b0;
`endif

  assign wr_en         = push_acc && !drop_beat;
  assign out_hs        = mem_q[rd_ptr_q];
  assign out_hs_ap_vld = (level_q != '0);
  assign level         = level_q;
  assign pkt_open      = pkt_open_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(pop_acc);
    level_d  = level_q + LW'(wr_en) - LW'(pop_acc);
    state_d  = state_q;
    if (push_acc) begin
      case (state_q)
        ST_IDLE: begin
`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
          if (!inStream_tlast) state_d = drop_beat ? ST_DROP : ST_MID_PKT;
`else
          if (!inStream_tlast) state_d = ST_MID_PKT;
`endif
        end
        default: begin
          if (inStream_tlast) state_d = ST_IDLE;
        end
      endcase
    end
    pkt_open_d = (state_d != ST_IDLE);
`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
    drop_err_d = drop_err_q || drop_beat;
`endif
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= ST_IDLE;
      pkt_open_q <= 1'b0;
`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
      drop_err_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      pkt_open_q <= pkt_open_d;
`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
      drop_err_q <= drop_err_d;
`endif
    end
  end

  // Storage is not reset; wr_en is low during reset because tready is
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {inStream_tdata, inStream_tdest, inStream_tlast};
  end

endmodule

// File: tb/tb_bsc_ompss_stream_to_hs_adapter.sv
// Randomized and directed bench for bsc_ompss_stream_to_hs_adapter against a queue-based model.
// Exercises the tid filter when BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN is defined.
module tb_bsc_ompss_stream_to_hs_adapter;

  localparam int DEPTH = 4;
  localparam int TIDW  = 4;
  localparam int ACCID = 2;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [63:0] tdata = '0;
  logic [2:0]  tdest = '0;
  logic [3:0]  tid = 4'd2;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [67:0] out_hs;
  logic        vld;
  logic        ack = 1'b0;
  logic [2:0]  level;
  logic        pkt_open;
`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
  logic        drop_err;
`endif

  bsc_ompss_stream_to_hs_adapter #(
    .FIFO_DEPTH(DEPTH), .TID_WIDTH(TIDW), .ACCID(ACCID)
  ) dut (
    .aclk(aclk), .areset(areset),
    .inStream_tdata(tdata), .inStream_tdest(tdest), .inStream_tid(tid),
    .inStream_tlast(tlast), .inStream_tvalid(tvalid), .inStream_tready(tready),
    .out_hs(out_hs), .out_hs_ap_vld(vld), .out_hs_ap_ack(ack),
    .level(level),
`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
    .pkt_open(pkt_open), .drop_err(drop_err)
`else
    .pkt_open(pkt_open)
`endif
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Reference model: a queue of packed words, packet state 0=idle 1=mid 2=drop, sticky error
  logic [67:0] mq[$];
  int          m_st = 0;
  bit          m_derr = 1'b0;

  task automatic chk(input string name, input logic [67:0] got, input logic [67:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      if (areset) begin
        mq.delete();
        m_st = 0;
        m_derr = 1'b0;
      end else begin
        bit push, pop, drop;
        push = tvalid && (mq.size() < DEPTH);
        pop  = (mq.size() != 0) && ack;
        if (pop) void'(mq.pop_front());
        if (push) begin
          drop = 1'b0;
`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
          drop = (m_st == 2) || (m_st == 0 && tid != 4'(ACCID));
          if (drop) m_derr = 1'b1;
`endif
          if (!drop) mq.push_back({tdata, tdest, tlast});
          if (tlast) m_st = 0;
          else if (m_st == 0) m_st = drop ? 2 : 1;
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (chk_on) begin
      chk("tready", tready, (!areset && mq.size() < DEPTH));
      chk("vld", vld, (mq.size() != 0));
      chk("level", level, mq.size());
      chk("pkt_open", pkt_open, (m_st != 0));
      if (mq.size() != 0) chk("out_hs", out_hs, mq[0]);
`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
      chk("drop_err", drop_err, m_derr);
`endif
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [2:0] dst, input logic lst,
                      input logic [3:0] id);
    bit acc;
    acc = 1'b0;
    tdata = d; tdest = dst; tlast = lst; tid = id; tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      acc = tready;
      step();
      if (acc) break;
    end
    tvalid = 1'b0;
    if (!acc) chk("send_timeout", 68'd0, 68'd1);
  endtask

  task automatic drain();
    ack = 1'b1;
    tvalid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!vld) break;
      step();
    end
    chk("drain_timeout", vld, 1'b0);
  endtask

  initial begin
    // Reset
    step();
    chk("rst_tready", tready, 1'b0);
    step();
    chk_on = 1'b1;
    areset = 1'b0;
    step();
    chk("post_rst_tready", tready, 1'b1);
    chk("post_rst_vld", vld, 1'b0);
    chk("post_rst_level", level, 3'd0);
    chk("post_rst_pkt", pkt_open, 1'b0);

    // Single word with ack held high
    ack = 1'b1;
    send(64'hDEADBEEF_00000001, 3'd5, 1'b1, 4'd2);
    chk("single_vld", vld, 1'b1);
    chk("single_data", out_hs, 68'hDEADBEEF00000001B);
    chk("single_level", level, 3'd1);
    chk("single_pkt", pkt_open, 1'b0);
    step();
    chk("single_level0", level, 3'd0);
    chk("single_vld0", vld, 1'b0);

    // Fill with ack low, then release
    ack = 1'b0;
    for (int i = 0; i < 4; i++) send(64'(i), 3'(i), 1'b1, 4'd2);
    chk("fill_tready", tready, 1'b0);
    chk("fill_level", level, 3'd4);
    tdata = 64'd4; tdest = 3'd4; tlast = 1'b1; tvalid = 1'b1;
    step();
    step();
    chk("fill_held_level", level, 3'd4);
    ack = 1'b1;
    step();
    chk("fill_tready_back", tready, 1'b1);
    chk("fill_level3", level, 3'd3);
    chk("fill_head1", out_hs, {64'd1, 3'd1, 1'b1});
    send(64'd4, 3'd4, 1'b1, 4'd2);
    send(64'd5, 3'd5, 1'b1, 4'd2);
    drain();

    // Simultaneous push and pop at level 2, across pointer wrap
    ack = 1'b0;
    send(64'h100, 3'd0, 1'b1, 4'd2);
    send(64'h101, 3'd1, 1'b1, 4'd2);
    ack = 1'b1;
    for (int j = 0; j < 20; j++) begin
      send(64'h200 + 64'(j), 3'(j), 1'b1, 4'd2);
      chk("sim_level", level, 3'd2);
    end
    drain();

    // Reset in the middle of a packet
    ack = 1'b0;
    for (int i = 0; i < 3; i++) send(64'h300 + 64'(i), 3'd3, 1'b0, 4'd2);
    chk("midrst_pkt_before", pkt_open, 1'b1);
    tdata = 64'hBAD; tdest = 3'd7; tlast = 1'b0; tvalid = 1'b1;
    areset = 1'b1;
    step();
    areset = 1'b0;
    tvalid = 1'b0;
    chk("midrst_vld", vld, 1'b0);
    chk("midrst_level", level, 3'd0);
    chk("midrst_pkt", pkt_open, 1'b0);
    ack = 1'b1;
    send(64'h400, 3'd2, 1'b0, 4'd2);
    send(64'h401, 3'd2, 1'b1, 4'd2);
    drain();

    // Packet tracking
    send(64'h500, 3'd1, 1'b0, 4'd2);
    chk("pkt_beat1", pkt_open, 1'b1);
    send(64'h501, 3'd1, 1'b0, 4'd2);
    chk("pkt_beat2", pkt_open, 1'b1);
    send(64'h502, 3'd1, 1'b1, 4'd2);
    chk("pkt_beat3", pkt_open, 1'b0);
    drain();

`ifdef BSC_OMPSS_STREAM_TO_HS_TID_FILTER_EN
    // Foreign packet dropped, own packet delivered
    ack = 1'b0;
    send(64'h600, 3'd1, 1'b0, 4'd3);
    chk("drop_pkt_open", pkt_open, 1'b1);
    send(64'h601, 3'd1, 1'b1, 4'd3);
    send(64'h123456789ABCDEF0, 3'd6, 1'b1, 4'd2);
    chk("drop_err_set", drop_err, 1'b1);
    chk("drop_level", level, 3'd1);
    chk("drop_keep", out_hs, 68'h123456789ABCDEF0D);
    drain();
    step();
    chk("drop_err_sticky", drop_err, 1'b1);
`endif

    // Randomized traffic with occasional reset
    for (int c = 0; c < 800; c++) begin
      areset = ($urandom_range(0, 99) == 0);
      tvalid = $urandom_range(0, 3) != 0;
      ack    = $urandom_range(0, 2) != 0;
      tdata  = {$urandom, $urandom};
      tdest  = 3'($urandom_range(0, 7));
      tlast  = $urandom_range(0, 3) == 0;
      tid    = 4'($urandom_range(0, 3));
      step();
    end
    areset = 1'b0;
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
